alu_sequencer: RTL and testbench
================================

# alu_sequencer

Microprogram sequencer that sits directly upstream of the ALU opcode decoder and drives its 4-bit opcode input. It fetches 20-bit instructions from an external synchronous program memory, issues ALU opcodes 0x0–0xE with a 16-bit operand to the datapath, and interprets opcode 0xF locally as a sequencer control instruction (HALT, LOOP_SET, LOOP_BACK). It lets one Skein round schedule run from a single start pulse.

## Interface
- PC_W, 10, program counter, loop target and loop counter width
- IDLE_OP, 4'hE, opcode driven whenever no ALU instruction is issued; 0xE drives all control lines low
- clk_i  input  1  clock; all logic rising-edge
- rst_i  input  1  reset, synchronous, active-high
- start_i  input  1  begin execution at base_addr_i; sampled only in IDLE
- base_addr_i  input  PC_W  program start address, sampled with start_i
- hold_i  input  1  stall ALU issue while high (datapath busy)
- prog_en_o  output  1  program memory read enable
- prog_addr_o  output  PC_W  program memory read address
- prog_data_i  input  20  instruction; valid the cycle after prog_en_o; [19:16] opcode, [15:0] immediate
- opcode_o  output  4  opcode to decoder; IDLE_OP unless issue_o
- operand_o  output  16  immediate for the issued instruction
- issue_o  output  1  one-cycle strobe: opcode_o/operand_o are a real instruction
- busy_o  output  1  sequencer not in IDLE
- done_o  output  1  one-cycle pulse after HALT executes

## Operation
- States: IDLE, FETCH, LOAD, EXEC.
- IDLE: start_i=1 → pc_q ← base_addr_i, loop_cnt_q ← 0, go FETCH. start_i in any other state is ignored.
- FETCH: prog_en_o=1, prog_addr_o=pc_q; go LOAD.
- LOAD: ir_q ← prog_data_i; go EXEC.
- EXEC, ir opcode 0x0–0xE: if hold_i=1, stay in EXEC with no issue. Otherwise register opcode/operand, pulse issue_o, set pc_q ← pc_q+1, and go FETCH.
- EXEC, opcode 0xF: hold_i is ignored. The subcode is imm[15:14]:
  - 00 HALT: go IDLE and pulse done_o.
  - 01 LOOP_SET: loop_cnt_q ← imm[PC_W-1:0], pc_q+1.
  - 10 LOOP_BACK: if loop_cnt_q≠0, decrement it and set pc_q ← imm[PC_W-1:0]. Otherwise pc_q+1.
  - 11 reserved: NOP, pc_q+1.
  - No issue_o for any 0xF instruction.
- LOOP_SET N followed by LOOP_BACK gives N+1 executions of the body. There is a single counter, so no nesting.
- pc_q+1 wraps from 2^PC_W−1 to 0.
- Registered outputs: opcode_o, operand_o, issue_o, done_o, busy_o.
- Reset values: opcode_o=IDLE_OP, operand_o=0, issue_o=0, done_o=0, busy_o=0, prog_en_o=0, prog_addr_o=0, pc_q=0, loop_cnt_q=0, state=IDLE.
- Reset mid-program aborts immediately: no done_o, no further issue.

## Timing
- Edge 0 samples start_i. Cycle 1: FETCH, prog_en_o=1, prog_addr_o=base, busy_o=1. Cycle 2: LOAD. Cycle 3: EXEC.
- Cycle 4: issue_o=1 with the first opcode/operand, concurrent with FETCH of base+1.
- Throughput is one instruction per 3 cycles with no hold.
- Each EXEC cycle with hold_i=1 adds one cycle. Hold is sampled in EXEC only, so it must be asserted by the EXEC cycle to block that issue.
- issue_o is never high two consecutive cycles. Outside issue cycles, opcode_o=IDLE_OP and operand_o holds its last value.
- Cycle after HALT's EXEC: done_o=1, busy_o=0, state IDLE. A start_i in that same cycle is accepted.
- prog_en_o is high only in FETCH. prog_addr_o holds its value outside FETCH.

## Test plan
- Reset, then program {0x0_1234, 0xF_0000} at base 5, pulse start_i.
  - prog_addr_o=5 in cycle 1.
  - Cycle 4: issue_o=1, opcode_o=0x0, operand_o=0x1234.
  - done_o=1 at cycle 7; busy_o cycles 1–6.
- Loop program {0xF_4003, 0x3_0000, 0xF_8001, 0xF_0000} at base 0.
  - Exactly 4 issues of opcode 0x3, spaced 6 cycles apart.
  - Then done_o; loop_cnt_q=0 at end.
- Two ALU instructions with hold_i=1 for 5 cycles during the first EXEC.
  - First issue is delayed exactly 5 cycles; opcode_o=0xE throughout the hold.
  - Hold asserted during a LOOP_SET EXEC adds no delay.
- base_addr_i=1023 with PC_W=10, program {0x7_00FF at 1023, 0xF_0000 at 0}.
  - prog_addr_o goes 1023 then 0; XOR issued, then done_o.
- start_i pulsed while busy: ignored, program completes unchanged.
  - rst_i asserted mid-program: next cycle all outputs at reset values, no done_o.
  - Reserved 0xF_C000 executes as NOP with no issue.

Source files
------------

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - microprogram sequencer feeding the ALU opcode decoder
module alu_sequencer #(
    parameter int          PC_W    = 10,
    parameter logic [3:0]  IDLE_OP = 4'hE
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [PC_W-1:0] base_addr_i,
    input  logic            hold_i,
    output logic            prog_en_o,
    output logic [PC_W-1:0] prog_addr_o,
    input  logic [19:0]     prog_data_i,
    output logic [3:0]      opcode_o,
    output logic [15:0]     operand_o,
    output logic            issue_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    localparam logic [3:0]      CTRL_OP = 4'hF;
    localparam logic [1:0]      SUB_HALT      = 2'b00;
    localparam logic [1:0]      SUB_LOOP_SET  = 2'b01;
    localparam logic [1:0]      SUB_LOOP_BACK = 2'b10;
    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] loop_cnt_q, loop_cnt_d;
    logic [PC_W-1:0] prog_addr_q, prog_addr_d;
    logic [19:0]     ir_q, ir_d;
    logic [3:0]      opcode_q, opcode_d;
    logic [15:0]     operand_q, operand_d;
    logic            issue_q, issue_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            prog_en_q, prog_en_d;

    // Decoded fields of the instruction held for EXEC.
    logic [3:0]      ir_op;
    logic [1:0]      ir_sub;
    logic [PC_W-1:0] ir_target;
    logic [PC_W-1:0] pc_inc;
    logic            unused_imm_bits;

    assign ir_op     = ir_q[19:16];
    assign ir_sub    = ir_q[15:14];
    assign ir_target = ir_q[PC_W-1:0];
    assign pc_inc    = pc_q + PC_ONE;   // natural wrap at 2^PC_W
    assign unused_imm_bits = ^ir_q[13:PC_W];

    // Next-state, program counter, loop counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        loop_cnt_d = loop_cnt_q;
        ir_d       = ir_q;
        opcode_d   = IDLE_OP;
        operand_d  = operand_q;
        issue_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_d       = base_addr_i;
                    loop_cnt_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                ir_d    = prog_data_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (ir_op != CTRL_OP) begin
                    // ALU instruction: the datapath may stall us before issue.
                    if (!hold_i) begin
                        opcode_d  = ir_op;
                        operand_d = ir_q[15:0];
                        issue_d   = 1'b1;
                        pc_d      = pc_inc;
                        state_d   = S_FETCH;
                    end
                end else begin
                    // Local control instruction: never stalled, never issued.
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                    case (ir_sub)
                        SUB_HALT: begin
                            pc_d    = pc_q;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                        SUB_LOOP_SET: begin
                            loop_cnt_d = ir_target;
                        end
                        SUB_LOOP_BACK: begin
                            if (loop_cnt_q != '0) begin
                                loop_cnt_d = loop_cnt_q - PC_ONE;
                                pc_d       = ir_target;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        prog_en_d   = (state_d == S_FETCH);
        prog_addr_d = (state_d == S_FETCH) ? pc_d : prog_addr_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            loop_cnt_q  <= '0;
            ir_q        <= '0;
            prog_addr_q <= '0;
            prog_en_q   <= 1'b0;
            opcode_q    <= IDLE_OP;
            operand_q   <= '0;
            issue_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            loop_cnt_q  <= loop_cnt_d;
            ir_q        <= ir_d;
            prog_addr_q <= prog_addr_d;
            prog_en_q   <= prog_en_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            issue_q     <= issue_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign prog_en_o   = prog_en_q;
    assign prog_addr_o = prog_addr_q;
    assign opcode_o    = opcode_q;
    assign operand_o   = operand_q;
    assign issue_o     = issue_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;

    localparam int         PC_W    = 10;
    localparam int         MAXC    = 1024;
    localparam logic [3:0] IDLE_OP = 4'hE;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [PC_W-1:0] base_addr_i;
    logic            hold_i;
    logic            prog_en_o;
    logic [PC_W-1:0] prog_addr_o;
    logic [19:0]     prog_data_i;
    logic [3:0]      opcode_o;
    logic [15:0]     operand_o;
    logic            issue_o;
    logic            busy_o;
    logic            done_o;

    alu_sequencer #(.PC_W(PC_W), .IDLE_OP(IDLE_OP)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .hold_i      (hold_i),
        .prog_en_o   (prog_en_o),
        .prog_addr_o (prog_addr_o),
        .prog_data_i (prog_data_i),
        .opcode_o    (opcode_o),
        .operand_o   (operand_o),
        .issue_o     (issue_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // External synchronous program memory: data valid the cycle after the read.
    logic [19:0] mem [0:1023];
    always @(posedge clk) if (prog_en_o) prog_data_i <= mem[prog_addr_o];

    int vectors = 0;
    int errors  = 0;

    // Reference trace, indexed by cycle number relative to the start edge.
    bit          hold_pat  [MAXC];
    bit          exp_issue [MAXC];
    bit          exp_done  [MAXC];
    bit          exp_en    [MAXC];
    logic [3:0]  exp_op    [MAXC];
    logic [15:0] exp_opd   [MAXC];
    logic [9:0]  exp_addr  [MAXC];
    int          exp_len;
    logic [9:0]  exp_lc;
    logic [15:0] last_operand = 16'h0;
    logic [9:0]  last_addr    = 10'h0;

    typedef struct {
        int          base;
        int          n;
        logic [19:0] p0, p1, p2, p3;
        int          hs, hl, pulse;
        int          n_iss, first, done;
        logic [3:0]  op;
        logic [15:0] opd;
    } vec_t;
    vec_t tab [6];

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int base, input int n,
                           input logic [19:0] p0, input logic [19:0] p1, input logic [19:0] p2, input logic [19:0] p3,
                           input int hs, input int hl, input int pulse,
                           input int n_iss, input int first, input logic [3:0] op, input logic [15:0] opd, input int done);
        tab[i].base = base; tab[i].n = n;
        tab[i].p0 = p0; tab[i].p1 = p1; tab[i].p2 = p2; tab[i].p3 = p3;
        tab[i].hs = hs; tab[i].hl = hl; tab[i].pulse = pulse;
        tab[i].n_iss = n_iss; tab[i].first = first; tab[i].op = op; tab[i].opd = opd; tab[i].done = done;
    endtask

    // Instruction-level interpreter: each instruction is fetch, load, exec;
    // ALU exec repeats while hold is high and its issue appears the next cycle.
    function automatic void model(input int base);
        int t, e, pc, steps;
        logic [9:0]  lc;
        logic [19:0] w;
        logic [15:0] cur_opd;
        logic [9:0]  cur_addr;
        bit          fin;
        for (int i = 0; i < MAXC; i++) begin
            exp_issue[i] = 0; exp_done[i] = 0; exp_en[i] = 0;
            exp_op[i] = IDLE_OP; exp_opd[i] = 16'h0; exp_addr[i] = 10'h0;
        end
        t = 1; pc = base; lc = 10'h0; steps = 0; fin = 0; exp_len = MAXC - 1;
        while (!fin && t + 3 < MAXC && steps < 1000) begin
            steps++;
            w = mem[pc];
            exp_en[t] = 1;
            exp_addr[t] = pc[9:0];
            if (w[19:16] != 4'hF) begin
                e = t + 2;
                while (e < MAXC - 2 && hold_pat[e]) e++;
                exp_issue[e+1] = 1;
                exp_op[e+1]    = w[19:16];
                exp_opd[e+1]   = w[15:0];
                pc = (pc + 1) % 1024;
                t  = e + 1;
            end else begin
                case (w[15:14])
                    2'b00: begin exp_done[t+3] = 1; exp_len = t + 3; fin = 1; end
                    2'b01: begin lc = w[9:0]; pc = (pc + 1) % 1024; end
                    2'b10: begin
                        if (lc != 10'h0) begin lc = lc - 10'h1; pc = int'(w[9:0]); end
                        else pc = (pc + 1) % 1024;
                    end
                    default: pc = (pc + 1) % 1024;
                endcase
                t = t + 3;
            end
        end
        exp_lc = lc;
        cur_opd = last_operand;
        cur_addr = last_addr;
        for (int i = 1; i < MAXC; i++) begin
            if (exp_issue[i]) cur_opd = exp_opd[i]; else exp_opd[i] = cur_opd;
            if (exp_en[i]) cur_addr = exp_addr[i]; else exp_addr[i] = cur_addr;
        end
    endfunction

    task automatic do_reset();
        rst_i = 1'b1; start_i = 1'b0; hold_i = 1'b0; base_addr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        last_operand = 16'h0;
        last_addr = 10'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_issue"},   0, 32'(issue_o),     32'd0);
        chk({tag, "_done"},    0, 32'(done_o),      32'd0);
        chk({tag, "_busy"},    0, 32'(busy_o),      32'd0);
        chk({tag, "_prog_en"}, 0, 32'(prog_en_o),   32'd0);
        chk({tag, "_addr"},    0, 32'(prog_addr_o), 32'd0);
        chk({tag, "_opcode"},  0, 32'(opcode_o),    32'(IDLE_OP));
        chk({tag, "_operand"}, 0, 32'(operand_o),   32'd0);
        chk({tag, "_loopcnt"}, 0, 32'(dut.loop_cnt_q), 32'd0);
    endtask

    // Starts a program (caller has already run model) and checks every cycle against the trace.
    task automatic run(input int base, input int pulse_at,
                       output int n_iss, output int first_cyc, output logic [3:0] first_op,
                       output logic [15:0] first_opd, output int done_cyc);
        int rel;
        n_iss = 0; first_cyc = -1; first_op = 4'h0; first_opd = 16'h0; done_cyc = -1;
        base_addr_i = base[PC_W-1:0];
        start_i = 1'b1;
        hold_i = 1'b0;
        rel = 0;
        while (done_cyc < 0 && rel < MAXC - 2) begin
            @(posedge clk);
            #1;
            rel++;
            start_i = (rel == pulse_at);
            hold_i = hold_pat[rel];
            chk("issue", rel, 32'(issue_o), 32'(exp_issue[rel]));
            chk("opcode", rel, 32'(opcode_o), 32'(exp_issue[rel] ? exp_op[rel] : IDLE_OP));
            chk("operand", rel, 32'(operand_o), 32'(exp_opd[rel]));
            chk("done", rel, 32'(done_o), 32'(exp_done[rel]));
            chk("busy", rel, 32'(busy_o), 32'(rel < exp_len));
            chk("prog_en", rel, 32'(prog_en_o), 32'(exp_en[rel]));
            chk("prog_addr", rel, 32'(prog_addr_o), 32'(exp_addr[rel]));
            if (issue_o) begin
                if (n_iss == 0) begin first_cyc = rel; first_op = opcode_o; first_opd = operand_o; end
                n_iss++;
            end
            if (done_o) done_cyc = rel;
        end
        if (done_cyc < 0) begin
            vectors++;
            errors++;
            $display("FAIL timeout: no done_o within %0d cycles, expected at %0d", rel, exp_len);
        end
        start_i = 1'b0;
        chk("loop_cnt_end", rel, 32'(dut.loop_cnt_q), 32'(exp_lc));
        last_operand = exp_opd[rel];
        last_addr = exp_addr[rel];
    endtask

    function automatic void put(inout int a, input logic [19:0] w);
        mem[a] = w;
        a = (a + 1) % 1024;
    endfunction

    function automatic void gen_prog(input int base);
        int a, nseg, body;
        a = base;
        nseg = $urandom_range(1, 5);
        for (int s = 0; s < nseg; s++) begin
            case ($urandom % 4)
                0, 1: put(a, {4'($urandom_range(0, 14)), 16'($urandom)});
                2:    put(a, {4'hF, 2'b11, 14'($urandom)});
                default: begin
                    put(a, {4'hF, 2'b01, 4'h0, 10'($urandom_range(0, 3))});
                    body = a;
                    for (int k = 0; k < int'($urandom_range(1, 2)); k++)
                        put(a, {4'($urandom_range(0, 14)), 16'($urandom)});
                    put(a, {4'hF, 2'b10, 4'h0, 10'(body)});
                end
            endcase
        end
        put(a, {4'hF, 2'b00, 14'($urandom)});
    endfunction

    initial begin
        int n_iss, first_cyc, done_cyc, pulse;
        logic [3:0]  first_op;
        logic [15:0] first_opd;

        //       idx base n  p0         p1         p2         p3         hs hl pls iss first op     opd       done
        set_vec(0, 5,    2, 20'h01234, 20'hF0000, 20'h0,     20'h0,     0, 0, 0,  1,  4,    4'h0, 16'h1234, 7);
        set_vec(1, 0,    4, 20'hF4003, 20'h30000, 20'hF8001, 20'hF0000, 0, 0, 5,  4,  7,    4'h3, 16'h0000, 31);
        set_vec(2, 0,    3, 20'h10001, 20'h20002, 20'hF0000, 20'h0,     3, 5, 0,  2,  9,    4'h1, 16'h0001, 15);
        set_vec(3, 0,    3, 20'hF4000, 20'h10001, 20'hF0000, 20'h0,     3, 1, 0,  1,  7,    4'h1, 16'h0001, 10);
        set_vec(4, 1023, 2, 20'h700FF, 20'hF0000, 20'h0,     20'h0,     0, 0, 0,  1,  4,    4'h7, 16'h00FF, 7);
        set_vec(5, 100,  3, 20'hFC000, 20'h50055, 20'hF0000, 20'h0,     0, 0, 2,  1,  7,    4'h5, 16'h0055, 10);

        for (int i = 0; i < 1024; i++) mem[i] = 20'hF0000;
        prog_data_i = 20'h0;
        do_reset();
        chk_reset_outputs("reset");

        for (int i = 0; i < 6; i++) begin
            logic [19:0] pw [4];
            pw[0] = tab[i].p0; pw[1] = tab[i].p1; pw[2] = tab[i].p2; pw[3] = tab[i].p3;
            for (int c = 0; c < MAXC; c++) hold_pat[c] = (c >= tab[i].hs && c < tab[i].hs + tab[i].hl);
            for (int j = 0; j < tab[i].n; j++) mem[(tab[i].base + j) % 1024] = pw[j];
            model(tab[i].base);
            run(tab[i].base, tab[i].pulse, n_iss, first_cyc, first_op, first_opd, done_cyc);
            chk("tab_n_issue", i, 32'(n_iss), 32'(tab[i].n_iss));
            chk("tab_first_cycle", i, 32'(first_cyc), 32'(tab[i].first));
            chk("tab_first_op", i, 32'(first_op), 32'(tab[i].op));
            chk("tab_first_operand", i, 32'(first_opd), 32'(tab[i].opd));
            chk("tab_done_cycle", i, 32'(done_cyc), 32'(tab[i].done));
            do_reset();
        end

        // A start in the done cycle is accepted: FETCH follows immediately.
        mem[5] = 20'h01234; mem[6] = 20'hF0000;
        for (int c = 0; c < MAXC; c++) hold_pat[c] = 0;
        model(5);
        run(5, 0, n_iss, first_cyc, first_op, first_opd, done_cyc);
        start_i = 1'b1;
        base_addr_i = 10'd200;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("restart_prog_en", 1, 32'(prog_en_o), 32'd1);
        chk("restart_addr", 1, 32'(prog_addr_o), 32'd200);
        chk("restart_busy", 1, 32'(busy_o), 32'd1);
        do_reset();

        // Reset mid-program aborts: reset values next cycle, then silence.
        mem[0] = 20'hF4003; mem[1] = 20'h3ABCD; mem[2] = 20'hF8001; mem[3] = 20'hF0000;
        base_addr_i = '0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk_reset_outputs("midreset");
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("post_reset_issue", c, 32'(issue_o), 32'd0);
            chk("post_reset_done", c, 32'(done_o), 32'd0);
            chk("post_reset_busy", c, 32'(busy_o), 32'd0);
        end
        last_operand = 16'h0;
        last_addr = 10'h0;

        // Randomized programs, hold patterns and stray start pulses, back to back.
        for (int r = 0; r < 30; r++) begin
            int base;
            base = $urandom_range(0, 1023);
            if (r % 5 == 0) base = 1020 + (r % 4);
            gen_prog(base);
            for (int c = 0; c < MAXC; c++) hold_pat[c] = ($urandom % 4 == 0);
            model(base);
            pulse = $urandom_range(1, exp_len - 1);
            run(base, pulse, n_iss, first_cyc, first_op, first_opd, done_cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
